// File: rtl/pipe_pkg.sv
// Shared widths and bundle field offsets for the pipeline-stage registers.
package pipe_pkg;

    // ID/EX boundary
    localparam int IDEX_CTRL_W = 16;
    localparam int IDEX_DATA_W = 197;

    // ID/EX control bundle, LSB offsets
    localparam int IDEX_ALUOP_LSB      = 0;   // [3]
    localparam int IDEX_WBSEL_LSB      = 3;   // [2]
    localparam int IDEX_RWSEL_LSB      = 5;   // [2]
    localparam int IDEX_RFWR_BIT       = 7;
    localparam int IDEX_DMWR_BIT       = 8;
    localparam int IDEX_LTYPEEXTOP_LSB = 9;   // [3]
    localparam int IDEX_LTYPESEL_BIT   = 12;
    localparam int IDEX_ALUSRCA_BIT    = 13;
    localparam int IDEX_ALUSRCB_BIT    = 14;
    localparam int IDEX_READMEN_BIT    = 15;

    typedef struct packed {
        logic       read_men;
        logic       alu_src_b;
        logic       alu_src_a;
        logic       ltype_sel;
        logic [2:0] ltype_ext_op;
        logic       dm_wr;
        logic       rf_wr;
        logic [1:0] rw_sel;
        logic [1:0] wb_sel;
        logic [2:0] alu_op;
    } idex_ctrl_t;

    // ID/EX data bundle, LSB offsets
    localparam int IDEX_BUSA_LSB     = 0;    // [32]
    localparam int IDEX_BUSB_LSB     = 32;   // [32]
    localparam int IDEX_IMM32_LSB    = 64;   // [32]
    localparam int IDEX_RS_LSB       = 96;   // [5]
    localparam int IDEX_RT_LSB       = 101;  // [5]
    localparam int IDEX_RD_LSB       = 106;  // [5]
    localparam int IDEX_OP_LSB       = 111;  // [6]
    localparam int IDEX_FUNCT_LSB    = 117;  // [6]
    localparam int IDEX_BOPCODE_LSB  = 123;  // [5]
    localparam int IDEX_PCADDONE_LSB = 128;  // [30], PC+1 word address [31:2]
    localparam int IDEX_S_LSB        = 158;  // [5], shift amount
    localparam int IDEX_SAVETYPE_LSB = 163;  // [2]
    localparam int IDEX_INSTR_LSB    = 165;  // [32]

    // Other boundaries
    localparam int IFID_CTRL_W  = 1;    // no decoded control yet; width kept non-zero
    localparam int IFID_DATA_W  = 62;   // PcAddOne[30] + Instr[32]
    localparam int EXMEM_CTRL_W = 11;   // WbSel, RwSel, RfWr, DmWr, LTypeExtOp, LTypeSel, ReadMen
    localparam int EXMEM_DATA_W = 133;  // AluOut, busB, rd, PcAddOne, SaveType, Instr
    localparam int MEMWB_CTRL_W = 5;    // WbSel, RwSel, RfWr
    localparam int MEMWB_DATA_W = 99;   // MemOut, AluOut, rd, PcAddOne

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: valid + control + datapath register.
// Control is zeroed whenever the slot becomes invalid; datapath only
// updates when a valid entry is written so it holds across bubbles.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int CTRL_W = IDEX_CTRL_W,
    parameter int DATA_W = IDEX_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic              valid_d,
    input  logic [CTRL_W-1:0] ctrl_d,
    input  logic [DATA_W-1:0] data_d,
    output logic              valid_q,
    output logic [CTRL_W-1:0] ctrl_q,
    output logic [DATA_W-1:0] data_q
);

    // Slot register: clear beats load; ctrl follows valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else if (clear) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else if (load) begin
            valid_q <= valid_d;
            ctrl_q  <= valid_d ? ctrl_d : '0;
            if (valid_d) data_q <= data_d;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready flow control, flush, optional
// skid slot and a saturating bubble counter. Outputs come only from the
// main slot; the skid slot absorbs the one input accepted during a stall.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = IDEX_CTRL_W,
    parameter int DATA_W = IDEX_DATA_W,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              in_fire, out_fire;
    logic              main_valid, main_load, main_valid_d;
    logic [CTRL_W-1:0] main_ctrl, main_ctrl_d;
    logic [DATA_W-1:0] main_data, main_data_d;
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [CNT_W-1:0]  bubble_q, bubble_d;

    // A flushed cycle's input is dropped even if in_ready was high.
    assign in_fire  = in_valid & in_ready & ~flush;
    assign out_fire = main_valid & out_ready;

    // Main refills whenever it drains or is empty; skid (older) wins over input.
    // Skid is never valid while main is empty, so the mux is safe then too.
    assign main_load    = out_fire | ~main_valid;
    assign main_valid_d = skid_valid | in_fire;
    assign main_ctrl_d  = skid_valid ? skid_ctrl : in_ctrl;
    assign main_data_d  = skid_valid ? skid_data : in_data;

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (main_load),
        .clear   (flush),
        .valid_d (main_valid_d),
        .ctrl_d  (main_ctrl_d),
        .data_d  (main_data_d),
        .valid_q (main_valid),
        .ctrl_q  (main_ctrl),
        .data_q  (main_data)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic skid_load, skid_valid_d;
            // Fill on an input accepted during a stall; empty when main takes it.
            assign skid_valid_d = in_fire & main_valid & ~out_ready;
            assign skid_load    = skid_valid_d | (out_fire & skid_valid);

            pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
                .clk     (clk),
                .rst_n   (rst_n),
                .load    (skid_load),
                .clear   (flush),
                .valid_d (skid_valid_d),
                .ctrl_d  (in_ctrl),
                .data_d  (in_data),
                .valid_q (skid_valid),
                .ctrl_q  (skid_ctrl),
                .data_q  (skid_data)
            );
            // Registered ready: straight off the skid valid flop.
            assign in_ready = ~skid_valid;
        end else begin : g_noskid
            assign skid_valid = 1'b0;
            assign skid_ctrl  = '0;
            assign skid_data  = '0;
            assign in_ready   = ~main_valid | out_ready;
        end
    endgenerate

    assign out_valid  = main_valid;
    assign out_ctrl   = main_ctrl & {CTRL_W{main_valid}};
    assign out_data   = main_data;
    assign bubble_cnt = bubble_q;

    // Bubble counter next state: clear first, then saturating increment.
    always_comb begin
        bubble_d = bubble_q;
        if (cnt_clr)
            bubble_d = '0;
        else if (out_ready && !main_valid && (bubble_q != {CNT_W{1'b1}}))
            bubble_d = bubble_q + CNT_W'(1);
    end

    // Bubble counter register; flush does not touch it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bubble_q <= '0;
        else        bubble_q <= bubble_d;
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue model for the SKID=1 instance checked every
// cycle, plus directed literal checks on SKID=1, SKID=0 and CNT_W=4 builds.
module tb_pipe_stage_reg;

    localparam int CW = 16;
    localparam int DW = 197;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // SKID=1, CNT_W=16
    logic          in_valid = 0, in_ready, flush = 0, out_valid, out_ready = 1, cnt_clr = 0;
    logic [CW-1:0] in_ctrl = '0, out_ctrl;
    logic [DW-1:0] in_data = '0, out_data;
    logic [15:0]   bubble_cnt;
    // SKID=0
    logic          in_valid0 = 0, in_ready0, flush0 = 0, out_valid0, out_ready0 = 1, cnt_clr0 = 0;
    logic [CW-1:0] in_ctrl0 = '0, out_ctrl0;
    logic [DW-1:0] in_data0 = '0, out_data0;
    logic [15:0]   bubble_cnt0;
    // CNT_W=4
    logic          in_valid4 = 0, in_ready4, flush4 = 0, out_valid4, out_ready4 = 1, cnt_clr4 = 0;
    logic [CW-1:0] in_ctrl4 = '0, out_ctrl4;
    logic [DW-1:0] in_data4 = '0, out_data4;
    logic [3:0]    bubble_cnt4;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .cnt_clr(cnt_clr), .bubble_cnt(bubble_cnt));

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_ctrl(in_ctrl0), .in_data(in_data0), .flush(flush0), .out_valid(out_valid0),
        .out_ready(out_ready0), .out_ctrl(out_ctrl0), .out_data(out_data0),
        .cnt_clr(cnt_clr0), .bubble_cnt(bubble_cnt0));

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_ctrl(in_ctrl4), .in_data(in_data4), .flush(flush4), .out_valid(out_valid4),
        .out_ready(out_ready4), .out_ctrl(out_ctrl4), .out_data(out_data4),
        .cnt_clr(cnt_clr4), .bubble_cnt(bubble_cnt4));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // ---- model: a two-deep FIFO; head is what the stage presents ----
    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] mcnt = '0;

    function automatic void model_reset();
        mq.delete();
        mcnt = '0;
    endfunction

    function automatic void model_step();
        bit have, room;
        have = (mq.size() > 0);
        room = (mq.size() < 2);
        if (cnt_clr)                                   mcnt = '0;
        else if (out_ready && !have && mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
        if (flush) begin
            mq.delete();
        end else begin
            if (have && out_ready) void'(mq.pop_front());
            if (in_valid && room)  mq.push_back('{c: in_ctrl, d: in_data});
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    // Compare SKID=1 instance against the model every cycle
    always @(negedge clk) begin
        if (mq.size() > 0) begin
            chk("m_out_valid", 256'(out_valid), 256'(1));
            chk("m_out_ctrl",  256'(out_ctrl),  256'(mq[0].c));
            chk("m_out_data",  256'(out_data),  256'(mq[0].d));
        end else begin
            chk("m_out_valid", 256'(out_valid), 256'(0));
            chk("m_out_ctrl",  256'(out_ctrl),  256'(0));
        end
        chk("m_in_ready",   256'(in_ready),   256'(mq.size() < 2));
        chk("m_bubble_cnt", 256'(bubble_cnt), 256'(mcnt));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 256'(out_valid), 256'(0));
        chk("rst_out_ctrl",  256'(out_ctrl),  256'(0));
        chk("rst_out_data",  256'(out_data),  256'(0));
        chk("rst_in_ready",  256'(in_ready),  256'(1));
        chk("rst_bubble",    256'(bubble_cnt), 256'(0));

        // 8 back-to-back inputs, out_ready high
        rst_n    = 1'b1;
        in_valid = 1'b1;
        in_ctrl  = 16'h0001;
        in_data  = DW'(32'h100);
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("stream_ctrl",  256'(out_ctrl), 256'(k));
            chk("stream_data",  256'(out_data), 256'(32'h100 + k - 1));
            chk("stream_ready", 256'(in_ready), 256'(1));
            if (k < 8) begin
                in_ctrl = CW'(k + 1);
                in_data = DW'(32'h100 + k);
            end else begin
                in_valid = 1'b0;
            end
        end
        chk("stream_bubble", 256'(bubble_cnt), 256'(1));
        step();

        // stall with skid fill
        in_valid  = 1'b1;
        in_ctrl   = 16'hA5A5;
        in_data   = DW'(1);
        out_ready = 1'b0;
        step();
        chk("skid_ctrl1", 256'(out_ctrl), 256'(16'hA5A5));
        chk("skid_rdy1",  256'(in_ready), 256'(1));
        in_ctrl = 16'h5A5A;
        in_data = DW'(2);
        step();
        in_valid = 1'b0;
        chk("skid_rdy_full", 256'(in_ready), 256'(0));
        chk("skid_hold1",    256'(out_data), 256'(1));
        step();
        chk("skid_hold2", 256'(out_data), 256'(1));
        step();
        chk("skid_hold3", 256'(out_data), 256'(1));
        chk("skid_hold3c", 256'(out_ctrl), 256'(16'hA5A5));
        out_ready = 1'b1;
        step();
        chk("skid_rel_ctrl", 256'(out_ctrl), 256'(16'h5A5A));
        chk("skid_rel_data", 256'(out_data), 256'(2));
        chk("skid_rel_rdy",  256'(in_ready), 256'(1));
        step();
        chk("skid_drained", 256'(out_valid), 256'(0));

        // flush with stage full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 16'h0011;
        in_data   = DW'(16'h11);
        step();
        in_ctrl = 16'h0022;
        in_data = DW'(16'h22);
        step();
        chk("fl_full", 256'(in_ready), 256'(0));
        flush   = 1'b1;
        in_ctrl = 16'hFFFF;
        in_data = DW'(16'hFFFF);
        step();
        chk("fl_valid", 256'(out_valid), 256'(0));
        chk("fl_ctrl",  256'(out_ctrl),  256'(0));
        chk("fl_ready", 256'(in_ready),  256'(1));
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("fl_no_emerge", 256'(out_valid), 256'(0));
        end

        // flush drops an input even when in_ready is high
        in_valid  = 1'b1;
        in_ctrl   = 16'h0033;
        out_ready = 1'b0;
        step();
        chk("fl2_loaded", 256'(out_ctrl), 256'(16'h0033));
        flush   = 1'b1;
        in_ctrl = 16'hFFFF;
        step();
        chk("fl2_valid", 256'(out_valid), 256'(0));
        chk("fl2_ready", 256'(in_ready),  256'(1));
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("fl2_no_emerge", 256'(out_valid), 256'(0));

        // SKID=0: combinational in_ready
        in_valid0  = 1'b1;
        in_ctrl0   = 16'h000A;
        in_data0   = DW'(10);
        out_ready0 = 1'b0;
        #1;
        chk("s0_rdy_empty", 256'(in_ready0), 256'(1));
        step();
        chk("s0_load", 256'(out_ctrl0), 256'(16'h000A));
        in_ctrl0 = 16'h000B;
        in_data0 = DW'(11);
        #1;
        chk("s0_rdy_stall", 256'(in_ready0), 256'(0));
        step();
        chk("s0_hold_ctrl", 256'(out_ctrl0), 256'(16'h000A));
        chk("s0_hold_data", 256'(out_data0), 256'(10));
        out_ready0 = 1'b1;
        #1;
        chk("s0_rdy_release", 256'(in_ready0), 256'(1));
        step();
        chk("s0_new_ctrl", 256'(out_ctrl0), 256'(16'h000B));
        chk("s0_new_data", 256'(out_data0), 256'(11));
        in_valid0 = 1'b0;
        step();
        chk("s0_empty", 256'(out_valid0), 256'(0));

        // CNT_W=4 saturation and clear priority
        cnt_clr4 = 1'b1;
        step();
        chk("c4_clr", 256'(bubble_cnt4), 256'(0));
        cnt_clr4 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("c4_ten", 256'(bubble_cnt4), 256'(10));
        repeat (10) @(posedge clk);
        #1;
        chk("c4_sat", 256'(bubble_cnt4), 256'(15));
        cnt_clr4 = 1'b1;
        step();
        chk("c4_clr_prio", 256'(bubble_cnt4), 256'(0));
        cnt_clr4 = 1'b0;

        // async reset mid-stall with both slots full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 16'h0041;
        in_data   = DW'(16'h41);
        step();
        in_ctrl = 16'h0042;
        in_data = DW'(16'h42);
        step();
        in_valid = 1'b0;
        chk("ar_full", 256'(in_ready), 256'(0));
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid",  256'(out_valid),  256'(0));
        chk("ar_ctrl",   256'(out_ctrl),   256'(0));
        chk("ar_data",   256'(out_data),   256'(0));
        chk("ar_bubble", 256'(bubble_cnt), 256'(0));
        chk("ar_ready",  256'(in_ready),   256'(1));
        step();
        rst_n = 1'b1;
        step();
        chk("ar_after", 256'(out_valid), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised pipeline-stage register. It replaces the fixed, always-loading ID/EX-style latches.
- Adds valid/ready flow control, synchronous flush (bubble insertion), an optional skid slot, and a bubble-cycle performance counter.
- One instance sits between each pair of stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- The payload is split into a control bundle, forced to zero for bubbles, and a datapath bundle, which is don't-care for bubbles.

Parameters:
- CTRL_W, 16: width of the control bundle (write enables, mux selects). Zeroed whenever the slot is invalid.
- DATA_W, 197: width of the datapath bundle (bus values, immediates, register indices, PC, instruction word).
- SKID, 1: 1 gives a two-entry stage with registered in_ready; 0 gives a single-entry stage with combinational in_ready.
- CNT_W, 16: width of the saturating bubble counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream stage holds a valid instruction
- in_ready  out  1  stage can accept this cycle
- in_ctrl  in  CTRL_W  control bundle from upstream
- in_data  in  DATA_W  datapath bundle from upstream
- flush  in  1  synchronous kill of all contents and of the current input
- out_valid  out  1  stage holds a valid instruction
- out_ready  in  1  downstream accepts; low means stall
- out_ctrl  out  CTRL_W  control bundle; all-zero when out_valid=0
- out_data  out  DATA_W  datapath bundle
- cnt_clr  in  1  synchronous clear of bubble_cnt
- bubble_cnt  out  CNT_W  saturating count of cycles with out_ready=1 and out_valid=0

Behaviour:
- Reset (rst_n=0, asynchronous, any time including mid-transfer):
  - main_valid=0, skid_valid=0; main/skid ctrl and data registers = 0; bubble_cnt=0.
  - out_valid=0, out_ctrl=0, out_data=0, in_ready=1 while in reset and after release.
- Handshakes:
  - Input transfer: in_valid & in_ready at a rising edge.
  - Output transfer: out_valid & out_ready.
  - out_valid, out_ctrl and out_data come from the main register only. There is no combinational input-to-output path.
- Latency: 1 cycle from input transfer to out_valid when the stage is empty.
- SKID=0:
  - in_ready = !main_valid | out_ready (combinational).
  - Main loads on input transfer. Otherwise main_valid clears on output transfer.
- SKID=1:
  - in_ready = !skid_valid (registered). Full throughput with out_ready held high.
  - Input transfer while main_valid & !out_ready: the input goes to skid.
  - Output transfer: main loads skid if skid_valid (skid empties). Otherwise main loads the input if it transfers, else main empties.
  - Input transfer while main is empty: the input goes to main.
  - Order is preserved. Skid is never valid while main is invalid.
  - Simultaneous output transfer and input transfer with skid_valid=1 cannot occur, because in_ready=0.
- Flush (highest priority after reset), at the next edge:
  - main_valid=0, skid_valid=0, main/skid ctrl = 0.
  - An input presented in the same cycle is discarded even if in_ready=1.
  - Data registers are not required to clear.
  - out_ready is ignored for that edge. The downstream stage is responsible for discarding an output it sampled in the flush cycle.
- Stall: out_ready=0 holds main (and skid) bit-exact, including out_data.
- Bubble gating: out_ctrl = main_ctrl AND {CTRL_W{main_valid}}. Main_ctrl is also written to 0 whenever main goes invalid.
- bubble_cnt:
  - Increments when out_ready=1 & out_valid=0.
  - Saturates at 2^CNT_W-1; no wrap.
  - cnt_clr has priority over increment.
  - Unaffected by flush.

Decomposition:
- Shared package pipe_pkg holds:
  - IDEX_CTRL_W=16 and IDEX_DATA_W=197.
  - Bit-field offset constants for the ID/EX control bundle: AluOp[3], WbSel[2], RwSel[2], RfWr, DmWr, LTypeExtOp[3], LTypeSel, AluSrcA, AluSrcB, ReadMen.
  - Bit-field offset constants for the ID/EX data bundle: busA, busB, Imm32, rs, rt, rd, OP[6], Funct, Bopcode, PcAddOne[31:2], S, SaveType, Instr.
  - Matching widths for the other stage boundaries.
- One natural sub-module, pipe_slot: a valid + ctrl + data register with load, clear and async reset. Instantiated as main, and as skid under generate when SKID=1.

Test Plan:
- Reset, then stream 8 back-to-back inputs (ctrl=16'h0001..0008) with out_ready=1, SKID=1 -> outputs appear 1 cycle later in order, in_ready stays 1, and bubble_cnt=1 (the first idle cycle).
- Load ctrl=16'hA5A5/data=1, drop out_ready for 3 cycles, offer ctrl=16'h5A5A/data=2 -> second goes to skid, in_ready=0 on the next cycle, out_data holds 1 while stalled; on release, outputs 1 then 2.
- Stage full (main+skid), assert flush with in_valid=1 ctrl=16'hFFFF -> next cycle out_valid=0, out_ctrl=0, in_ready=1, and the 16'hFFFF input never emerges.
- SKID=0 build, out_ready=0 with main valid -> in_ready=0 in the same cycle; raise out_ready -> in_ready=1 in the same cycle and the new input loads.
- Idle with out_ready=1 and CNT_W=4 for 20 cycles -> bubble_cnt saturates at 15; pulse cnt_clr together with an increment condition -> bubble_cnt=0.
- Drop rst_n asynchronously mid-stall with both slots valid -> out_valid=0, out_ctrl=0, out_data=0, bubble_cnt=0 immediately, without waiting for a clock edge.
